data_stack: RTL and testbench
=============================

DATA_STACK -- requirements
Module: data_stack

Interface
REQ-001 SHALL have parameter DEPTH, default 16, meaning the number of stack entries (legal range 4..32).
REQ-002 SHALL have parameter WIDTH, default 16, meaning the data word width in bits.
REQ-003 SHALL have port clk, input, 1 bit: the single clock; all state changes occur on its rising edge.
REQ-004 SHALL have port rst, input, 1 bit: reset, synchronous and active-high.
REQ-005 SHALL have port push, input, 1 bit: push request from the control-signal decoder.
REQ-006 SHALL have port pop, input, 1 bit: pop request from the control-signal decoder.
REQ-007 SHALL have port load_stk, input, 1 bit: write stk_in into the top entry.
REQ-008 SHALL have port stk_in, input, WIDTH bits: new top value (ALU result or memory read data, muxed externally).
REQ-009 SHALL have port stk0, output, WIDTH bits: current top entry, driven directly from a register.
REQ-010 SHALL have port stk1, output, WIDTH bits: current second entry, driven directly from a register.
REQ-011 SHALL have port depth, output, $clog2(DEPTH)+1 bits: number of valid entries, 0..DEPTH.
REQ-012 SHALL have port overflow, input-independent output, 1 bit: sticky flag for push at full.
REQ-013 SHALL have port underflow, output, 1 bit: sticky flag for pop at empty.
REQ-014 SHALL have port conflict, output, 1 bit: sticky flag for push and pop asserted together.

Function
REQ-015 SHALL hold entries e[0..DEPTH-1] as registers, with e[0] the top, stk0=e[0] and stk1=e[1].
REQ-016 With push=1, pop=0 and load_stk=1, SHALL set e[0]<=stk_in, set e[i]<=e[i-1] for i>=1, and set depth+1.
REQ-017 With push=1, pop=0 and load_stk=0, SHALL set e[i]<=e[i-1] for i>=1, keep e[0] (dup), and set depth+1.
REQ-018 With pop=1, push=0 and load_stk=1, SHALL set e[0]<=stk_in (binary op result), set e[i]<=e[i+1] for 1<=i<DEPTH-1, set e[DEPTH-1]<=0, and set depth-1.
REQ-019 With pop=1, push=0 and load_stk=0, SHALL set e[i]<=e[i+1] for i<DEPTH-1, set e[DEPTH-1]<=0, and set depth-1.
REQ-020 With push=0, pop=0 and load_stk=1, SHALL set e[0]<=stk_in only; depth is unchanged.
REQ-021 With push=0, pop=0 and load_stk=0, SHALL leave all state unchanged.
REQ-022 Write latency SHALL be one cycle: a new value is visible on stk0/stk1/depth the cycle after the qualifying edge; there is no handshake, and every request is accepted in the cycle it is asserted.
REQ-023 Push at full (depth==DEPTH): SHALL perform the data shift (e[DEPTH-1] lost), keep depth==DEPTH, and set overflow.
REQ-024 Pop at empty (depth==0): SHALL perform the data shift, keep depth==0 (no wrap to all-ones), and set underflow.
REQ-025 push=1 and pop=1 in the same cycle is illegal: SHALL set conflict, leave entries and depth unchanged, and ignore load_stk.
REQ-026 overflow, underflow and conflict SHALL remain set until rst; they SHALL NOT alter subsequent operation.
REQ-027 depth arithmetic SHALL be unsigned saturating in 0..DEPTH.

Reset
REQ-028 When rst=1 at a rising edge, SHALL clear all entries to 0, depth to 0, and overflow/underflow/conflict to 0.
REQ-029 rst SHALL take priority over push/pop/load_stk in the same cycle, including mid-sequence, and no request issued during rst shall take effect.
REQ-030 The first request honoured after reset SHALL be the one sampled at the first edge with rst=0.

Verification
REQ-031 Reset, then push+load 0x00A5, then push+load 0x0003 -> stk0=0x0003, stk1=0x00A5, depth=2, all flags 0.
REQ-032 From REQ-031 state, pop+load stk_in=0x00A8 (add result) -> stk0=0x00A8, stk1=0x0000, depth=1; then load_stk only with 0xFF57 (NOT) -> stk0=0xFF57, depth=1.
REQ-033 Push+load values 1..16 with DEPTH=16 -> depth=16, overflow=0; a 17th push of 0x0011 -> stk0=0x0011, depth=16, overflow=1, and the value 1 is lost.
REQ-034 From reset, pop alone -> depth=0, underflow=1, stk0=0; a following push+load 0x1234 -> depth=1, stk0=0x1234, underflow still 1.
REQ-035 With depth=2 (stk0=0x0003, stk1=0x00A5), push=pop=load_stk=1 with stk_in=0xBEEF -> contents unchanged, depth=2, conflict=1.
REQ-036 With push+load 0x5555 issued in the same cycle as rst=1 at depth=3 -> depth=0, stk0=0, stk1=0, all flags 0.

Source files
------------

// File: rtl/data_stack.sv
// Register-based operand stack: the top two entries are exposed directly and
// every request is accepted on the edge where it is sampled. The error flags stay set until reset.
module data_stack #(
  parameter int unsigned DEPTH = 16,
  parameter int unsigned WIDTH = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic                     pop,
  input  logic                     load_stk,
  input  logic [WIDTH-1:0]         stk_in,
  output logic [WIDTH-1:0]         stk0,
  output logic [WIDTH-1:0]         stk1,
  output logic [$clog2(DEPTH):0]   depth,
  output logic                     overflow,
  output logic                     underflow,
  output logic                     conflict
);

  localparam int unsigned DW = $clog2(DEPTH) + 1;

  logic [WIDTH-1:0] e_q [DEPTH];
  logic [WIDTH-1:0] e_d [DEPTH];
  logic [DW-1:0]    depth_q, depth_d;
  logic             overflow_q, overflow_d;
  logic             underflow_q, underflow_d;
  logic             conflict_q, conflict_d;

  // Next-state: shifts happen even at full/empty; only depth saturates.
  always_comb begin
    e_d         = e_q;
    depth_d     = depth_q;
    overflow_d  = overflow_q;
    underflow_d = underflow_q;
    conflict_d  = conflict_q;
    if (push && pop) begin
      conflict_d = 1'b1;
    end else if (push) begin
      for (int i = 1; i < int'(DEPTH); i++) e_d[i] = e_q[i-1];
      if (load_stk) e_d[0] = stk_in;
      if (depth_q == DW'(DEPTH)) overflow_d = 1'b1;
      else                       depth_d    = depth_q + DW'(1);
    end else if (pop) begin
      for (int i = 0; i < int'(DEPTH) - 1; i++) e_d[i] = e_q[i+1];
      e_d[DEPTH-1] = '0;
      if (load_stk) e_d[0] = stk_in;
      if (depth_q == DW'(0)) underflow_d = 1'b1;
      else                   depth_d     = depth_q - DW'(1);
    end else if (load_stk) begin
      e_d[0] = stk_in;
    end
  end

  // State register with synchronous reset overriding any request.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < int'(DEPTH); i++) e_q[i] <= '0;
      depth_q     <= '0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
      conflict_q  <= 1'b0;
    end else begin
      e_q         <= e_d;
      depth_q     <= depth_d;
      overflow_q  <= overflow_d;
      underflow_q <= underflow_d;
      conflict_q  <= conflict_d;
    end
  end

  assign stk0      = e_q[0];
  assign stk1      = e_q[1];
  assign depth     = depth_q;
  assign overflow  = overflow_q;
  assign underflow = underflow_q;
  assign conflict  = conflict_q;

endmodule

// File: tb/tb_data_stack.sv
// Directed + random bench for data_stack: a queue-based reference stack produces
// expected outputs that are scoreboarded against the DUT one cycle after each request.
module tb_data_stack;

  localparam int unsigned DEPTH = 16;
  localparam int unsigned WIDTH = 16;

  typedef struct {
    logic [WIDTH-1:0] s0;
    logic [WIDTH-1:0] s1;
    logic [4:0]       d;
    logic             ov;
    logic             un;
    logic             cf;
  } exp_t;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             push = 1'b0;
  logic             pop = 1'b0;
  logic             load_stk = 1'b0;
  logic [WIDTH-1:0] stk_in = '0;
  logic [WIDTH-1:0] stk0, stk1;
  logic [4:0]       depth;
  logic             overflow, underflow, conflict;

  int n_assert = 0;
  int n_fail   = 0;

  logic [WIDTH-1:0] m [$];
  int               md;
  logic             mo, mu, mc;
  exp_t             sb [$];

  data_stack #(.DEPTH(DEPTH), .WIDTH(WIDTH)) dut (
    .clk(clk), .rst(rst), .push(push), .pop(pop), .load_stk(load_stk),
    .stk_in(stk_in), .stk0(stk0), .stk1(stk1), .depth(depth),
    .overflow(overflow), .underflow(underflow), .conflict(conflict)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_clear();
    m.delete();
    for (int i = 0; i < int'(DEPTH); i++) m.push_back('0);
    md = 0; mo = 1'b0; mu = 1'b0; mc = 1'b0;
  endtask

  // Drive one request, advance the reference model, then score the DUT result.
  task automatic do_op(input bit r, input bit p, input bit q, input bit l,
                       input logic [WIDTH-1:0] v);
    exp_t e;
    logic [WIDTH-1:0] top;
    @(negedge clk);
    rst = r; push = p; pop = q; load_stk = l; stk_in = v;
    if (r) begin
      model_clear();
    end else if (p && q) begin
      mc = 1'b1;
    end else if (p) begin
      top = l ? v : m[0];
      m.push_front(top);
      void'(m.pop_back());
      if (md == int'(DEPTH)) mo = 1'b1; else md++;
    end else if (q) begin
      void'(m.pop_front());
      m.push_back('0);
      if (l) m[0] = v;
      if (md == 0) mu = 1'b1; else md--;
    end else if (l) begin
      m[0] = v;
    end
    e.s0 = m[0]; e.s1 = m[1]; e.d = 5'(md); e.ov = mo; e.un = mu; e.cf = mc;
    sb.push_back(e);
    @(posedge clk);
    #1;
    e = sb.pop_front();
    check("sb_stk0", 32'(stk0), 32'(e.s0));
    check("sb_stk1", 32'(stk1), 32'(e.s1));
    check("sb_depth", 32'(depth), 32'(e.d));
    check("sb_overflow", 32'(overflow), 32'(e.ov));
    check("sb_underflow", 32'(underflow), 32'(e.un));
    check("sb_conflict", 32'(conflict), 32'(e.cf));
  endtask

  task automatic idle();
    @(negedge clk);
    rst = 1'b0; push = 1'b0; pop = 1'b0; load_stk = 1'b0;
  endtask

  initial begin
    model_clear();
    do_op(1, 0, 0, 0, 16'h0000);
    do_op(1, 1, 0, 1, 16'hDEAD);
    check("reset_stk0", 32'(stk0), 32'h0);
    check("reset_depth", 32'(depth), 32'h0);
    check("reset_flags", {29'h0, overflow, underflow, conflict}, 32'h0);

    // Two pushes with load.
    do_op(0, 1, 0, 1, 16'h00A5);
    do_op(0, 1, 0, 1, 16'h0003);
    check("v031_stk0", 32'(stk0), 32'h0003);
    check("v031_stk1", 32'(stk1), 32'h00A5);
    check("v031_depth", 32'(depth), 32'd2);
    check("v031_flags", {29'h0, overflow, underflow, conflict}, 32'h0);

    // Simultaneous push and pop is ignored apart from the sticky flag.
    do_op(0, 1, 1, 1, 16'hBEEF);
    check("v035_stk0", 32'(stk0), 32'h0003);
    check("v035_stk1", 32'(stk1), 32'h00A5);
    check("v035_depth", 32'(depth), 32'd2);
    check("v035_conflict", 32'(conflict), 32'h1);

    // Binary op result replaces two operands, then unary op in place.
    do_op(0, 0, 1, 1, 16'h00A8);
    check("v032_stk0", 32'(stk0), 32'h00A8);
    check("v032_stk1", 32'(stk1), 32'h0000);
    check("v032_depth", 32'(depth), 32'd1);
    do_op(0, 0, 0, 1, 16'hFF57);
    check("v032_not", 32'(stk0), 32'hFF57);
    check("v032_depth2", 32'(depth), 32'd1);
    do_op(0, 0, 0, 0, 16'h1111);
    check("conflict_sticky", 32'(conflict), 32'h1);

    // Pop at empty then recover.
    do_op(1, 0, 0, 0, 16'h0);
    do_op(0, 0, 1, 0, 16'h0);
    check("v034_depth", 32'(depth), 32'd0);
    check("v034_underflow", 32'(underflow), 32'h1);
    check("v034_stk0", 32'(stk0), 32'h0);
    do_op(0, 1, 0, 1, 16'h1234);
    check("v034_depth2", 32'(depth), 32'd1);
    check("v034_stk0b", 32'(stk0), 32'h1234);
    check("v034_sticky", 32'(underflow), 32'h1);

    // Fill to full, overflow, and confirm the bottom value is lost.
    do_op(1, 0, 0, 0, 16'h0);
    for (int i = 1; i <= 16; i++) do_op(0, 1, 0, 1, 16'(i));
    check("v033_depth", 32'(depth), 32'd16);
    check("v033_noovf", 32'(overflow), 32'h0);
    do_op(0, 1, 0, 1, 16'h0011);
    check("v033_stk0", 32'(stk0), 32'h0011);
    check("v033_depth2", 32'(depth), 32'd16);
    check("v033_ovf", 32'(overflow), 32'h1);
    for (int i = 0; i < 15; i++) do_op(0, 0, 1, 0, 16'h0);
    check("v033_lost_stk0", 32'(stk0), 32'h0002);
    check("v033_lost_stk1", 32'(stk1), 32'h0000);
    check("v033_lost_depth", 32'(depth), 32'd1);

    // Dup then reset mid-sequence with a push pending.
    do_op(0, 1, 0, 0, 16'h9999);
    check("dup_stk1", 32'(stk1), 32'h0002);
    do_op(0, 1, 0, 1, 16'h7777);
    check("pre036_depth", 32'(depth), 32'd3);
    do_op(1, 1, 0, 1, 16'h5555);
    check("v036_depth", 32'(depth), 32'd0);
    check("v036_stk0", 32'(stk0), 32'h0);
    check("v036_stk1", 32'(stk1), 32'h0);
    check("v036_flags", {29'h0, overflow, underflow, conflict}, 32'h0);
    do_op(0, 1, 0, 1, 16'h4242);
    check("first_after_rst", 32'(stk0), 32'h4242);

    // Random traffic against the reference model.
    for (int i = 0; i < 400; i++) begin
      do_op(($urandom_range(0, 49) == 0), 1'($urandom), 1'($urandom),
            1'($urandom), 16'($urandom));
    end
    idle();

    check("sb_drained", 32'(sb.size()), 32'h0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
